// File: rtl/addsub_seq64_if.sv
// Operand/result handshake bundle for the chunked adder/subtractor.
// The master side is the upstream shifter plus downstream normalizer; the slave side is the adder.
interface addsub_seq64_if #(
  parameter int WIDTH = 64
);
  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             Sub;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Neg;
  logic [WIDTH-1:0] Mag;

  modport master (
    output InValid, X, Y, Sub, OutReady,
    input  InReady, OutValid, S, Cout, Neg, Mag
  );

  modport slave (
    input  InValid, X, Y, Sub, OutReady,
    output InReady, OutValid, S, Cout, Neg, Mag
  );
endinterface

// File: rtl/addsub_seq64.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle with a rippled carry, then an
// optional two's-complement pass producing the magnitude of a negative difference.
module addsub_seq64 #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic          clk,
  input  logic          reset,
  addsub_seq64_if.slave io_bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_NEG  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_cout;
  logic             r_neg;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] r_mag;

  logic [CHUNK-1:0] w_xc;
  logic [CHUNK-1:0] w_yc;
  logic [CHUNK-1:0] w_sc;
  logic [CHUNK:0]   w_add;
  logic [CHUNK:0]   w_inv;
  logic             w_accept;
  logic             w_last;

  assign w_xc     = r_x[r_cnt*CHUNK +: CHUNK];
  assign w_yc     = r_y[r_cnt*CHUNK +: CHUNK];
  assign w_sc     = r_s[r_cnt*CHUNK +: CHUNK];
  assign w_add    = {1'b0, w_xc} + {1'b0, w_yc} + {{CHUNK{1'b0}}, r_carry};
  assign w_inv    = {1'b0, ~w_sc} + {{CHUNK{1'b0}}, r_carry};
  assign w_accept = io_bus.InValid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == LAST);

  // Y is stored pre-inverted for subtraction so the ADD pass is a plain add with carry-in = Sub.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x <= io_bus.X;
      r_y <= io_bus.Y ^ {WIDTH{io_bus.Sub}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cout  <= 1'b0;
      r_neg   <= 1'b0;
      r_s     <= '0;
      r_mag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_carry <= io_bus.Sub;
            r_sub   <= io_bus.Sub;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          // Mag tracks S chunk by chunk; a following NEG pass overwrites it entirely.
          r_s[r_cnt*CHUNK +: CHUNK]   <= w_add[CHUNK-1:0];
          r_mag[r_cnt*CHUNK +: CHUNK] <= w_add[CHUNK-1:0];
          r_carry <= w_add[CHUNK];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_add[CHUNK];
            r_neg  <= r_sub & ~w_add[CHUNK];
            r_cnt  <= '0;
            if (r_sub & ~w_add[CHUNK]) begin
              r_carry <= 1'b1;
              r_state <= S_NEG;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_NEG: begin
          r_mag[r_cnt*CHUNK +: CHUNK] <= w_inv[CHUNK-1:0];
          r_carry <= w_inv[CHUNK];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (io_bus.OutReady) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.InReady  = (r_state == S_IDLE);
  assign io_bus.OutValid = (r_state == S_DONE);
  assign io_bus.S        = r_s;
  assign io_bus.Mag      = r_mag;
  assign io_bus.Cout     = r_cout;
  assign io_bus.Neg      = r_neg;
endmodule

// File: tb/tb_addsub_seq64.sv
// Bench for addsub_seq64: vector table plus scoreboard queue, with hand-written
// backpressure and mid-operation reset sequences.
module tb_addsub_seq64;
  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        sub;
    logic [63:0] s;
    logic [63:0] mag;
    logic        cout;
    logic        neg;
  } vec_t;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  vec_t sb_q[$];
  vec_t tbl[14];

  addsub_seq64_if #(.WIDTH(64)) bus ();

  addsub_seq64 #(.WIDTH(64), .CHUNK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic vec_t model(input logic [63:0] x, input logic [63:0] y, input logic sub);
    vec_t v;
    v.x = x; v.y = y; v.sub = sub;
    if (sub) begin
      v.s    = x - y;
      v.cout = (x >= y);
      v.neg  = (x < y);
      v.mag  = v.neg ? (y - x) : (x - y);
    end else begin
      {v.cout, v.s} = {1'b0, x} + {1'b0, y};
      v.neg = 1'b0;
      v.mag = v.s;
    end
    return v;
  endfunction

  function automatic vec_t mk(input logic [63:0] x, input logic [63:0] y, input logic sub,
                              input logic [63:0] s, input logic cout, input logic neg,
                              input logic [63:0] mag);
    vec_t v;
    v.x = x; v.y = y; v.sub = sub; v.s = s; v.cout = cout; v.neg = neg; v.mag = mag;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.X = v.x; bus.Y = v.y; bus.Sub = v.sub; bus.InValid = 1'b1;
  endtask

  // Waits from just after the accept edge for OutValid, then checks against the queue head.
  task automatic check_result(input string tag);
    int   n;
    bit   got;
    vec_t e;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (bus.OutValid === 1'b1) got = 1;
    end
    e = sb_q.pop_front();
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: OutValid not seen within 20 cycles", tag);
    end else begin
      chk({tag, "_latency"}, 64'(n), e.neg ? 64'd8 : 64'd4);
      chk({tag, "_S"}, bus.S, e.s);
      chk({tag, "_Mag"}, bus.Mag, e.mag);
      chk({tag, "_Cout"}, 64'(bus.Cout), 64'(e.cout));
      chk({tag, "_Neg"}, 64'(bus.Neg), 64'(e.neg));
      chk({tag, "_InReady_done"}, 64'(bus.InReady), 64'd0);
    end
  endtask

  task automatic release_out(input string tag);
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_OutValid_after"}, 64'(bus.OutValid), 64'd0);
    chk({tag, "_InReady_after"}, 64'(bus.InReady), 64'd1);
    bus.OutReady = 1'b0;
  endtask

  task automatic do_op(input vec_t v, input bit early_ready, input string tag);
    @(negedge clk);
    drive(v);
    bus.OutReady = early_ready;
    chk({tag, "_InReady_idle"}, 64'(bus.InReady), 64'd1);
    sb_q.push_back(v);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    bus.X = {$urandom, $urandom};
    bus.Y = {$urandom, $urandom};
    check_result(tag);
    release_out(tag);
  endtask

  initial begin
    vec_t v;
    logic [63:0] held_s, held_mag;
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    bus.InValid = 1'b0; bus.OutReady = 1'b0; bus.Sub = 1'b0;
    bus.X = '0; bus.Y = '0;

    tbl[0] = mk(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000);
    tbl[1] = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    tbl[2] = mk(64'h5, 64'h10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF5, 1'b0, 1'b1, 64'hB);
    tbl[3] = mk(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h0, 1'b1, 1'b0, 64'h0);
    tbl[4] = mk(64'h0, 64'h8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'h8000_0000_0000_0000);
    tbl[5] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0);
    tbl[6] = mk(64'h1_0000, 64'h1, 1'b1, 64'hFFFF, 1'b1, 1'b0, 64'hFFFF);
    tbl[7] = mk(64'h1, 64'h0001_0000_0000_0000, 1'b1, 64'hFFFF_0000_0000_0001, 1'b0, 1'b1, 64'h0000_FFFF_FFFF_FFFF);
    for (int i = 8; i < 14; i++)
      tbl[i] = model({$urandom, $urandom}, {$urandom, $urandom}, 1'(i % 2));

    #12;
    chk("rst_InReady", 64'(bus.InReady), 64'd1);
    chk("rst_OutValid", 64'(bus.OutValid), 64'd0);
    chk("rst_S", bus.S, 64'd0);
    chk("rst_Mag", bus.Mag, 64'd0);
    chk("rst_Cout", 64'(bus.Cout), 64'd0);
    chk("rst_Neg", 64'(bus.Neg), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      do_op(tbl[i], (i % 3) == 2, $sformatf("vec%0d", i));

    // Backpressure: DONE held for 10 cycles while new operands are offered.
    @(negedge clk);
    drive(tbl[2]);
    sb_q.push_back(tbl[2]);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    check_result("bp");
    held_s = bus.S; held_mag = bus.Mag;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.InValid = 1'b1; bus.X = {$urandom, $urandom}; bus.Y = 64'h1; bus.Sub = 1'b0;
      @(posedge clk); #1;
      if (bus.OutValid !== 1'b1 || bus.InReady !== 1'b0 || bus.S !== held_s || bus.Mag !== held_mag) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d: OutValid=%b InReady=%b S=%h Mag=%h expected 1 0 %h %h",
                 c, bus.OutValid, bus.InReady, bus.S, bus.Mag, tbl[2].s, tbl[2].mag);
      end
      n_cmp++;
    end
    chk("bp_held_S", held_s, tbl[2].s);
    @(negedge clk);
    v = model(64'h3, 64'h4, 1'b0);
    drive(v);
    bus.OutReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_OutValid", 64'(bus.OutValid), 64'd0);
    chk("bp_release_InReady", 64'(bus.InReady), 64'd1);
    bus.OutReady = 1'b0;
    sb_q.push_back(v);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    check_result("bp_next");
    release_out("bp_next");

    // Reset asserted during the second ADD cycle aborts the operation.
    @(negedge clk);
    drive(tbl[2]);
    @(posedge clk); #1;
    bus.InValid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("midrst_InReady", 64'(bus.InReady), 64'd1);
    chk("midrst_OutValid", 64'(bus.OutValid), 64'd0);
    chk("midrst_S", bus.S, 64'd0);
    chk("midrst_Mag", bus.Mag, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_output", 64'(bus.OutValid), 64'd0);
    do_op(tbl[3], 1'b0, "post_rst");
    do_op(tbl[7], 1'b0, "post_rst_neg");

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
